pixel_flush_seq: RTL
====================

Name: pixel_flush_seq

Overview:
- Sequencer that flushes the pixel cache into game-pak RAM through the bit-plane matrix (plane-select / dump / RAM-load stage).
- Sits directly downstream of the pixel cache and drives the matrix's pixel_sel, plane_sel, dump and ramdone controls.
- Owns the RAM bus request for the flush, including the read-modify-write read pass needed for partially filled caches.
- Write data is the matrix's planed output; this block supplies only address and control.

Parameters:
- ADDR_W, 17, RAM byte-address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush_req  in  1  one-cycle request to flush the cache; sampled only in IDLE
- pix_valid  in  8  per-pixel valid mask from the pixel cache; bit i corresponds to pixel i
- bpp_mode  in  2  colour depth: 0=2bpp (2 planes), 1=4bpp (4 planes), 2 or 3=8bpp (8 planes)
- base_addr  in  ADDR_W  address of plane 0 for the current tile row
- ram_ack  in  1  RAM access complete; for reads, ramd is valid in the same cycle
- flush_busy  out  1  high from flush accept until flush_done
- flush_done  out  1  one-cycle completion pulse
- pixel_sel  out  3  pixel index presented to the matrix
- plane_sel  out  3  plane index presented to the matrix
- dump  out  1  load the cache column into the matrix for pixel_sel
- ramdone  out  1  load ramd into the matrix for plane_sel
- ram_req  out  1  RAM access request
- ram_we  out  1  1 = write, 0 = read; valid while ram_req is high
- ram_addr  out  ADDR_W  RAM byte address

Behaviour:
- Reset (asynchronous, any state): all outputs 0; state=IDLE; counters 0; any in-flight access is abandoned and its ram_req drops immediately.
- Latches on accept: flush_req in IDLE captures pix_valid, bpp_mode and base_addr. Later changes on these inputs have no effect until the next accept.
- flush_req while busy: ignored; no queuing.
- Plane count N: 2, 4 or 8 per bpp_mode.
- Plane address: base + 16*(p>>1) + (p&1), computed mod 2^ADDR_W (wraps).
- States: IDLE, READ, DUMP, WRITE, DONE.
- IDLE -> DONE: latched mask == 8'h00; no RAM accesses, no dump.
- IDLE -> READ: mask is partial (neither 8'h00 nor 8'hFF).
- IDLE -> DUMP: mask == 8'hFF.
- READ:
  - For p=0..N-1: ram_req=1, ram_we=0, ram_addr=addr(p), plane_sel=p.
  - ram_req, ram_we and ram_addr stay stable until ram_ack.
  - ramdone = ram_ack in this state, same cycle.
  - On ack, advance p the next cycle; ram_req stays high across planes (back-to-back).
  - After plane N-1 acks -> DUMP.
- DUMP:
  - Exactly 8 cycles, pixel_sel = 0..7.
  - dump = latched pix_valid[pixel_sel]; ram_req=0.
  - Then -> WRITE.
- WRITE:
  - For p=0..N-1: ram_req=1, ram_we=1, ram_addr=addr(p), plane_sel=p; same hold/advance rules as READ.
  - ramdone=0.
  - After the last ack -> DONE.
- DONE: flush_done=1 for one cycle, flush_busy=0 in that cycle, then -> IDLE.
- flush_busy: high in READ, DUMP and WRITE.
- ram_ack outside READ/WRITE: ignored.
- plane_sel/pixel_sel: hold their last value when not meaningful; the bench checks them only while qualified.
- Latency with 8'hFF mask, 4bpp, ack every cycle:
  - accept at T
  - dump T+1..T+8
  - writes T+9..T+12
  - flush_done at T+13

Decomposition:
- Shared package:
  - state enum
  - bpp_mode encodings and the plane-count function
  - the plane-offset constant 16
- One natural sub-module: pixel_flush_addr_gen, combinational base + plane index -> ram_addr.
- Keep the FSM and counters in the top module.

Test Plan:
- Full mask 8'hFF, 4bpp, base=0x01000, ack held high -> no reads; dump on T+1..T+8; write addrs 0x01000, 0x01001, 0x01010, 0x01011 on T+9..T+12; flush_done at T+13.
- Partial mask 8'hA5, 2bpp, base=0x00200, ack 2 cycles after each req -> reads at 0x00200/0x00201 with ramdone on the ack cycles; dump only for pixels 0, 2, 5, 7; then writes to the same 2 addresses.
- 8bpp, base=0x1FFF0 -> write addrs 0x1FFF0, 0x1FFF1, 0x00000, 0x00001, 0x00010, 0x00011, 0x00020, 0x00021 (wrap).
- Mask 8'h00 -> flush_done one cycle after accept; ram_req, dump and ramdone never asserted.
- Second flush_req during WRITE, plus a pix_valid change after accept -> ignored; exactly one flush_done and the original mask is used.
- Reset asserted mid-READ with ram_req high -> ram_req, flush_busy and ramdone drop immediately; after release the block is in IDLE and accepts a new flush.

Source files
------------

// File: rtl/pixel_flush_seq_pkg.sv
// rtl/pixel_flush_seq_pkg.sv - shared types and constants for the pixel cache flush sequencer
package pixel_flush_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DUMP,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic [1:0] BPP_2 = 2'd0;
  localparam logic [1:0] BPP_4 = 2'd1;
  localparam logic [1:0] BPP_8 = 2'd2;

  // Plane pairs are interleaved: planes 2k and 2k+1 sit side by side, 16 bytes per pair.
  localparam int PLANE_STRIDE = 16;

  function automatic logic [3:0] plane_count(input logic [1:0] bpp);
    case (bpp)
      BPP_2:   return 4'd2;
      BPP_4:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/pixel_flush_addr_gen.sv
// rtl/pixel_flush_addr_gen.sv - tile row base plus plane index to RAM byte address
module pixel_flush_addr_gen
  import pixel_flush_seq_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        plane,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] offset;

  always_comb begin
    offset = ADDR_W'(PLANE_STRIDE * int'(plane[2:1]) + int'(plane[0]));
    addr   = base + offset;
  end

endmodule

// File: rtl/pixel_flush_seq.sv
// rtl/pixel_flush_seq.sv - sequences read-modify-write flush of the pixel cache through the bit-plane matrix
module pixel_flush_seq
  import pixel_flush_seq_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_req,
  input  logic [7:0]        pix_valid,
  input  logic [1:0]        bpp_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              ram_ack,
  output logic              flush_busy,
  output logic              flush_done,
  output logic [2:0]        pixel_sel,
  output logic [2:0]        plane_sel,
  output logic              dump,
  output logic              ramdone,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr
);

  state_e            state_q, state_d;
  logic [2:0]        plane_q, plane_d;
  logic [2:0]        pix_q, pix_d;
  logic [7:0]        mask_q, mask_d;
  logic [1:0]        bpp_q, bpp_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] plane_addr;
  logic              last_plane;

  pixel_flush_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .base  (base_q),
    .plane (plane_q),
    .addr  (plane_addr)
  );

  assign last_plane = ({1'b0, plane_q} == (plane_count(bpp_q) - 4'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      plane_q <= '0;
      pix_q   <= '0;
      mask_q  <= '0;
      bpp_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      pix_q   <= pix_d;
      mask_q  <= mask_d;
      bpp_q   <= bpp_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    pix_d   = pix_q;
    mask_d  = mask_q;
    bpp_d   = bpp_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          mask_d  = pix_valid;
          bpp_d   = bpp_mode;
          base_d  = base_addr;
          plane_d = '0;
          pix_d   = '0;
          // A full cache overwrites every byte, so the read pass is only needed for partial masks.
          if (pix_valid == 8'h00)      state_d = ST_DONE;
          else if (pix_valid == 8'hFF) state_d = ST_DUMP;
          else                         state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (ram_ack) begin
          if (last_plane) begin
            plane_d = '0;
            state_d = ST_DUMP;
          end else begin
            plane_d = plane_q + 3'd1;
          end
        end
      end
      ST_DUMP: begin
        pix_d = pix_q + 3'd1;
        if (pix_q == 3'd7) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (ram_ack) begin
          if (last_plane) begin
            plane_d = '0;
            state_d = ST_DONE;
          end else begin
            plane_d = plane_q + 3'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flush_busy = 1'b0;
    flush_done = 1'b0;
    dump       = 1'b0;
    ramdone    = 1'b0;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    pixel_sel  = pix_q;
    plane_sel  = plane_q;
    case (state_q)
      ST_READ: begin
        flush_busy = 1'b1;
        ram_req    = 1'b1;
        ramdone    = ram_ack;
      end
      ST_DUMP: begin
        flush_busy = 1'b1;
        dump       = mask_q[pix_q];
      end
      ST_WRITE: begin
        flush_busy = 1'b1;
        ram_req    = 1'b1;
        ram_we     = 1'b1;
      end
      ST_DONE: flush_done = 1'b1;
      default: ;
    endcase
    ram_addr = ram_req ? plane_addr : '0;
  end

endmodule
